// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the data-side memory access port between the CPU memory stage and
// the DMA/loader engine. One requester is granted per cycle, the memory port
// is driven combinationally from the winner, and read data returning one
// cycle later is steered back to whichever requester issued the read.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate on simultaneous
// requests; without it the CPU always wins a tie.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cpuReq/Wr/Addr/Wdata        CPU request, direction, word address, write data
//   dmaReq/Wr/Addr/Wdata        DMA request, direction, word address, write data
//   dmaLock                     DMA asks to keep ownership next cycle (burst)
//   cpuGnt, dmaGnt              combinational grant, same cycle as the request
//   cpuRvalid/Rdata             CPU read response, one cycle after grant
//   dmaRvalid/Rdata             DMA read response, one cycle after grant
//   memAccessAddress/Data       memory address and write data
//   memAccessWren/Rden          memory write / read strobes
//   memAccessOutput             memory read data, one cycle after Rden
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpuReq,
  input  logic                  cpuWr,
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  input  logic [DATA_WIDTH-1:0] cpuWdata,
  input  logic                  dmaReq,
  input  logic                  dmaWr,
  input  logic [ADDR_WIDTH-1:0] dmaAddr,
  input  logic [DATA_WIDTH-1:0] dmaWdata,
  input  logic                  dmaLock,
  output logic                  cpuGnt,
  output logic                  dmaGnt,
  output logic                  cpuRvalid,
  output logic                  dmaRvalid,
  output logic [DATA_WIDTH-1:0] cpuRdata,
  output logic [DATA_WIDTH-1:0] dmaRdata,
  output logic [ADDR_WIDTH-1:0] memAccessAddress,
  output logic                  memAccessWren,
  output logic                  memAccessRden,
  output logic [DATA_WIDTH-1:0] memAccessData,
  input  logic [DATA_WIDTH-1:0] memAccessOutput
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  logic             last_owner_q, last_owner_d;   // 0 = CPU, 1 = DMA
  logic             lock_active_q, lock_active_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rd_pending_q, rd_pending_d;
  logic             rd_owner_q, rd_owner_d;       // 0 = CPU, 1 = DMA

  logic             cpu_win, dma_win, any_win, wr_sel;
  logic [CNT_W-1:0] lock_inc;

  // Grant decision. After a forced lock release the last owner is the DMA,
  // so a requesting CPU wins the next tie in either build.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (!rst_n) begin
      cpu_win = 1'b0;
      dma_win = 1'b0;
    end else if (lock_active_q && dmaReq) begin
      dma_win = 1'b1;
    end else if (cpuReq && dmaReq) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (last_owner_q) cpu_win = 1'b1;
      else              dma_win = 1'b1;
`else
      cpu_win = 1'b1;
`endif
    end else if (cpuReq) begin
      cpu_win = 1'b1;
    end else if (dmaReq) begin
      dma_win = 1'b1;
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Owner history is kept for parity with the round-robin build only.
  logic unused_last_owner;
  assign unused_last_owner = last_owner_q;
`endif

  assign any_win = cpu_win | dma_win;
  assign wr_sel  = cpu_win ? cpuWr : dmaWr;
  assign cpuGnt  = cpu_win;
  assign dmaGnt  = dma_win;

  // Memory port driven straight from the winner; idle port is all zeros.
  always_comb begin
    memAccessAddress = '0;
    memAccessData    = '0;
    if (cpu_win) begin
      memAccessAddress = cpuAddr;
      memAccessData    = cpuWdata;
    end else if (dma_win) begin
      memAccessAddress = dmaAddr;
      memAccessData    = dmaWdata;
    end
  end

  assign memAccessWren = any_win &  wr_sel;
  assign memAccessRden = any_win & ~wr_sel;

  // Response steering; rst_n gating drops a response that lands in reset.
  assign cpuRvalid = rst_n & rd_pending_q & ~rd_owner_q;
  assign dmaRvalid = rst_n & rd_pending_q &  rd_owner_q;
  assign cpuRdata  = cpuRvalid ? memAccessOutput : '0;
  assign dmaRdata  = dmaRvalid ? memAccessOutput : '0;

  // Next state: owner history, lock/burst counting, read tracking.
  always_comb begin
    last_owner_d  = last_owner_q;
    rd_owner_d    = rd_owner_q;
    lock_inc      = lock_active_q ? lock_cnt_q + CNT_W'(1) : lock_cnt_q;
    // Lock persists only while the DMA keeps winning with dmaLock high and
    // the locked-grant count has not yet reached LOCK_MAX.
    lock_active_d = dma_win & dmaLock & (lock_inc != CNT_W'(LOCK_MAX));
    lock_cnt_d    = lock_active_d ? lock_inc : '0;
    rd_pending_d  = any_win & ~wr_sel;
    if (cpu_win) last_owner_d = 1'b0;
    if (dma_win) last_owner_d = 1'b1;
    if (rd_pending_d) rd_owner_d = dma_win;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_owner_q  <= 1'b0;
      lock_active_q <= 1'b0;
      lock_cnt_q    <= '0;
      rd_pending_q  <= 1'b0;
      rd_owner_q    <= 1'b0;
    end else begin
      last_owner_q  <= last_owner_d;
      lock_active_q <= lock_active_d;
      lock_cnt_q    <= lock_cnt_d;
      rd_pending_q  <= rd_pending_d;
      rd_owner_q    <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpuReq, cpuWr, dmaReq, dmaWr, dmaLock;
  logic [AW-1:0] cpuAddr, dmaAddr;
  logic [DW-1:0] cpuWdata, dmaWdata;
  logic          cpuGnt, dmaGnt, cpuRvalid, dmaRvalid;
  logic [DW-1:0] cpuRdata, dmaRdata;
  logic [AW-1:0] memAccessAddress;
  logic          memAccessWren, memAccessRden;
  logic [DW-1:0] memAccessData, memAccessOutput;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .dmaReq(dmaReq), .dmaWr(dmaWr), .dmaAddr(dmaAddr), .dmaWdata(dmaWdata),
    .dmaLock(dmaLock),
    .cpuGnt(cpuGnt), .dmaGnt(dmaGnt),
    .cpuRvalid(cpuRvalid), .dmaRvalid(dmaRvalid),
    .cpuRdata(cpuRdata), .dmaRdata(dmaRdata),
    .memAccessAddress(memAccessAddress), .memAccessWren(memAccessWren),
    .memAccessRden(memAccessRden), .memAccessData(memAccessData),
    .memAccessOutput(memAccessOutput)
  );

  // Behavioural memory: unwritten words read as {C0DE, address}.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] rd_q = '0;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {16'hC0DE, a};
  endfunction

  always @(posedge clk) begin
    if (memAccessWren) mem[memAccessAddress] = memAccessData;
    if (memAccessRden)
      rd_q <= mem.exists(memAccessAddress) ? mem[memAccessAddress] : init_word(memAccessAddress);
  end
  assign memAccessOutput = rd_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic idle();
    cpuReq = 1'b0; cpuWr = 1'b0; cpuAddr = '0; cpuWdata = '0;
    dmaReq = 1'b0; dmaWr = 1'b0; dmaAddr = '0; dmaWdata = '0; dmaLock = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset: requests are ignored and every output is zero.
    @(negedge clk); cpuReq = 1'b1; cpuAddr = 16'h0010; #1;
    check("rst_cpugnt", cpuGnt, 0);
    check("rst_rden",   memAccessRden, 0);
    check("rst_addr",   memAccessAddress, 0);
    check("rst_rvalid", {cpuRvalid, dmaRvalid}, 0);

    // CPU read of 0x0010 right after reset.
    @(negedge clk); rst_n = 1'b1; #1;
    check("rd_cpugnt", cpuGnt, 1);
    check("rd_dmagnt", dmaGnt, 0);
    check("rd_rden",   memAccessRden, 1);
    check("rd_addr",   memAccessAddress, 16'h0010);

    // Response for CPU; DMA writes DEADBEEF to 0x0100 in the same cycle.
    @(negedge clk); idle();
    dmaReq = 1'b1; dmaWr = 1'b1; dmaAddr = 16'h0100; dmaWdata = 32'hDEADBEEF; #1;
    check("rd_cpurvalid", cpuRvalid, 1);
    check("rd_cpurdata",  cpuRdata, 32'hC0DE0010);
    check("rd_dmarvalid", dmaRvalid, 0);
    check("rd_dmardata",  dmaRdata, 0);
    check("wr_dmagnt",    dmaGnt, 1);
    check("wr_wren",      memAccessWren, 1);
    check("wr_data",      memAccessData, 32'hDEADBEEF);

    // CPU reads back 0x0100.
    @(negedge clk); idle(); cpuReq = 1'b1; cpuAddr = 16'h0100; #1;
    check("rb_cpugnt", cpuGnt, 1);
    check("rb_wren",   memAccessWren, 0);

    // Read-back data; a DMA write leaves the DMA as last owner.
    @(negedge clk); idle();
    dmaReq = 1'b1; dmaWr = 1'b1; dmaAddr = 16'h0200; dmaWdata = 32'h1; #1;
    check("rb_cpurdata", cpuRdata, 32'hDEADBEEF);
    check("rb_dmagnt",   dmaGnt, 1);

    // Simultaneous writes for 4 cycles, no lock.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpuReq = 1'b1; cpuWr = 1'b1; cpuAddr = AW'(16'h0300 + i);
      dmaReq = 1'b1; dmaWr = 1'b1; dmaAddr = AW'(16'h0400 + i); #1;
      check($sformatf("tie_cpugnt%0d", i), cpuGnt, (RR ? (i % 2 == 0) : 1'b1));
      check($sformatf("tie_dmagnt%0d", i), dmaGnt, (RR ? (i % 2 == 1) : 1'b0));
    end

    // Locked DMA burst with LOCK_MAX = 4; CPU requests from the second cycle.
    @(negedge clk); idle();
    dmaReq = 1'b1; dmaWr = 1'b1; dmaLock = 1'b1; dmaAddr = 16'h0500; #1;
    check("lk_first_dma", dmaGnt, 1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); cpuReq = 1'b1; cpuWr = 1'b1; cpuAddr = 16'h0600; #1;
      if (i <= 4) begin
        check($sformatf("lk_dma%0d", i), dmaGnt, 1);
      end else if (i == 5) begin
        check("lk_release_cpu", cpuGnt, 1);
      end else begin
        check("lk_after_dma", dmaGnt, RR);
        check("lk_after_cpu", cpuGnt, !RR);
      end
    end

    @(negedge clk); idle(); #1;
    check("idle_gnt", {cpuGnt, dmaGnt, memAccessWren, memAccessRden}, 0);

    // Pipelined reads CPU@1, DMA@2, CPU@3.
    @(negedge clk); idle(); cpuReq = 1'b1; cpuAddr = 16'h0001; #1;
    check("pl_gnt1", cpuGnt, 1);
    @(negedge clk); idle(); dmaReq = 1'b1; dmaAddr = 16'h0002; #1;
    check("pl_gnt2", dmaGnt, 1);
    check("pl_rv1", {cpuRvalid, dmaRvalid}, 2'b10);
    check("pl_rd1", cpuRdata, 32'hC0DE0001);
    @(negedge clk); idle(); cpuReq = 1'b1; cpuAddr = 16'h0003; #1;
    check("pl_gnt3", cpuGnt, 1);
    check("pl_rv2", {cpuRvalid, dmaRvalid}, 2'b01);
    check("pl_rd2", dmaRdata, 32'hC0DE0002);
    @(negedge clk); idle(); #1;
    check("pl_rv3", {cpuRvalid, dmaRvalid}, 2'b10);
    check("pl_rd3", cpuRdata, 32'hC0DE0003);

    // Reset in the cycle after a granted read.
    @(negedge clk); idle(); cpuReq = 1'b1; cpuAddr = 16'h0020; #1;
    check("mr_gnt", cpuGnt, 1);
    @(negedge clk); idle(); rst_n = 1'b0; #1;
    check("mr_rvalid", {cpuRvalid, dmaRvalid}, 0);
    check("mr_rdata",  cpuRdata, 0);
    check("mr_mem",    {memAccessAddress, memAccessData, memAccessWren, memAccessRden}, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("mr_post1", {cpuRvalid, dmaRvalid, cpuGnt, dmaGnt}, 0);
    @(negedge clk); #1;
    check("mr_post2", {cpuRvalid, dmaRvalid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
